io_pad_in_filter: RTL and testbench

- Per-pin input conditioning stage that consumes the raw p2c outputs of the input, tri-state and Schmitt pad cells.
- Each pin passes through a multi-flop synchronizer, then an optional programmable glitch/debounce filter, then rising/falling edge detection with sticky interrupt-pending bits.
- Sits between the pad ring and the GPIO/peripheral register blocks, so no core logic ever samples an asynchronous pad signal directly.

---
 rtl/io_pad_in_filter.sv | 120 ++++++++++++
 tb/tb_io_pad_in_filter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/io_pad_in_filter.sv
// Input conditioning for the raw pad-to-core levels. Each pin is synchronized,
// optionally debounced by a per-pin counter against a shared threshold, and
// then edge-detected. Enabled edges set sticky interrupt-pending bits.
// SYNC_STAGES is meant to be 2..4.

module io_pad_in_filter #(
    parameter int NUM         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NUM-1:0]   p2c_i,
    input  logic [NUM-1:0]   filt_en_i,
    input  logic [CNT_W-1:0] filt_thresh_i,
    input  logic [NUM-1:0]   rise_irq_en_i,
    input  logic [NUM-1:0]   fall_irq_en_i,
    input  logic [NUM-1:0]   irq_clr_i,
    output logic [NUM-1:0]   val_o,
    output logic [NUM-1:0]   rise_o,
    output logic [NUM-1:0]   fall_o,
    output logic [NUM-1:0]   irq_pend_o,
    output logic             irq_o
);

    // Synchronizer stages; index 0 samples the pad, the last stage is safe to use.
    logic [NUM-1:0]   sync_q [SYNC_STAGES];
    logic [NUM-1:0]   sync;

    logic [CNT_W-1:0] cnt_q  [NUM];
    logic [CNT_W-1:0] cnt_d  [NUM];
    logic [NUM-1:0]   val_q;
    logic [NUM-1:0]   val_d;
    logic [NUM-1:0]   rise_q;
    logic [NUM-1:0]   fall_q;
    logic [NUM-1:0]   pend_q;

    logic [CNT_W-1:0] thresh_m1;
    logic             thresh_zero;

    assign sync        = sync_q[SYNC_STAGES-1];
    assign thresh_zero = (filt_thresh_i == '0);
    // Only consumed when the threshold is non-zero, so the wrap at 0 is harmless.
    assign thresh_m1   = filt_thresh_i - CNT_W'(1);

    // Plain flop chain per pin, no logic between stages.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // predecessor's old value; blocking would collapse the chain.
            sync_q[0] <= p2c_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Next filtered level and counter per pin (bypass or debounce).
    always_comb begin
        // NOTE: defaults first so every path assigns every bit; otherwise a
        // latch is inferred for the paths that leave a signal untouched.
        val_d = val_q;
        for (int i = 0; i < NUM; i++) begin
            cnt_d[i] = '0;
            if (!filt_en_i[i] || thresh_zero) begin
                val_d[i] = sync[i];
            end else if (sync[i] == val_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thresh_m1) begin
                // >= rather than == so a lowered threshold takes effect at once.
                val_d[i] = sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Filtered level, counters and edge pulses registered together so a pulse
    // appears in the same cycle as the new level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            val_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            val_q  <= val_d;
            rise_q <= val_d & ~val_q;
            fall_q <= ~val_d & val_q;
            for (int i = 0; i < NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Sticky pending bits; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~irq_clr_i)
                    | (rise_q & rise_irq_en_i)
                    | (fall_q & fall_irq_en_i);
        end
    end

    assign val_o      = val_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign irq_pend_o = pend_q;
    // Pure OR of flops, so it cannot glitch.
    assign irq_o      = |pend_q;

endmodule

// File: tb/tb_io_pad_in_filter.sv
// Directed bench for io_pad_in_filter with default parameters (NUM=8,
// SYNC_STAGES=2, CNT_W=8). Inputs change 1ns after a rising edge and outputs
// are sampled at that same point, so each tick() is one clock of latency.

module tb_io_pad_in_filter;

    localparam int NUM   = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [NUM-1:0]   p2c;
    logic [NUM-1:0]   filt_en;
    logic [CNT_W-1:0] thresh;
    logic [NUM-1:0]   rise_en;
    logic [NUM-1:0]   fall_en;
    logic [NUM-1:0]   clr;
    logic [NUM-1:0]   val;
    logic [NUM-1:0]   rise;
    logic [NUM-1:0]   fall;
    logic [NUM-1:0]   pend;
    logic             irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    io_pad_in_filter #(.NUM(NUM), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .p2c_i         (p2c),
        .filt_en_i     (filt_en),
        .filt_thresh_i (thresh),
        .rise_irq_en_i (rise_en),
        .fall_irq_en_i (fall_en),
        .irq_clr_i     (clr),
        .val_o         (val),
        .rise_o        (rise),
        .fall_o        (fall),
        .irq_pend_o    (pend),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        p2c     = '0;
        filt_en = '0;
        thresh  = '0;
        rise_en = '0;
        fall_en = '0;
        clr     = '0;

        // Reset state
        repeat (2) tick();
        check("rst_val",  32'(val),  32'h0);
        check("rst_rise", 32'(rise), 32'h0);
        check("rst_fall", 32'(fall), 32'h0);
        check("rst_pend", 32'(pend), 32'h0);
        check("rst_irq",  32'(irq),  32'h0);
        rst_n = 1'b1;
        tick();

        // Pin 0 bypass: val after 3 cycles with a single rise pulse
        p2c[0] = 1'b1;
        tick(); check("byp_val_c1", 32'(val), 32'h00);
        tick(); check("byp_val_c2", 32'(val), 32'h00);
        tick(); check("byp_val_c3", 32'(val), 32'h01);
        check("byp_rise_c3", 32'(rise), 32'h01);
        check("byp_fall_c3", 32'(fall), 32'h00);
        tick(); check("byp_rise_c4", 32'(rise), 32'h00);
        check("byp_val_c4", 32'(val), 32'h01);

        // Pin 1 filter, threshold 4: a 3-cycle glitch is discarded
        filt_en[1] = 1'b1;
        thresh     = 8'd4;
        p2c[1]     = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) p2c[1] = 1'b0;
            check($sformatf("glitch_val_c%0d", k), 32'(val[1]), 32'h0);
            check($sformatf("glitch_rise_c%0d", k), 32'(rise[1]), 32'h0);
        end

        // 4-cycle pulse passes at cycle 2+4, then falls 4 mismatching cycles later
        p2c[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) p2c[1] = 1'b0;
            check($sformatf("pulse_val_c%0d", k), 32'(val[1]), 32'(k == 6));
            check($sformatf("pulse_rise_c%0d", k), 32'(rise[1]), 32'(k == 6));
        end
        for (int k = 7; k <= 10; k++) begin
            tick();
            check($sformatf("pulse_val_c%0d", k), 32'(val[1]), 32'(k < 10));
            check($sformatf("pulse_fall_c%0d", k), 32'(fall[1]), 32'(k == 10));
        end

        // Pin 2: rising-edge interrupt only
        rise_en[2] = 1'b1;
        p2c[2]     = 1'b1;
        repeat (3) tick();
        check("irq2_rise", 32'(rise[2]), 32'h1);
        check("irq2_pend_early", 32'(pend), 32'h00);
        tick();
        check("irq2_pend_set", 32'(pend), 32'h04);
        check("irq2_irq_set", 32'(irq), 32'h1);
        p2c[2] = 1'b0;
        repeat (3) tick();
        check("irq2_fall", 32'(fall[2]), 32'h1);
        tick();
        check("irq2_pend_after_fall", 32'(pend), 32'h04);
        clr[2] = 1'b1;
        tick();
        clr = '0;
        check("irq2_pend_clr", 32'(pend), 32'h00);
        check("irq2_irq_clr", 32'(irq), 32'h0);

        // Pin 3: clear coincides with an enabled fall pulse -> set wins
        fall_en[3] = 1'b1;
        p2c[3]     = 1'b1;
        repeat (4) tick();
        check("irq3_no_rise_pend", 32'(pend), 32'h00);
        p2c[3] = 1'b0;
        repeat (3) tick();
        check("irq3_fall", 32'(fall[3]), 32'h1);
        clr[3] = 1'b1;
        tick();
        clr = '0;
        check("irq3_set_wins", 32'(pend), 32'h08);
        fall_en[3] = 1'b0;
        tick();
        check("irq3_en_off_keeps", 32'(pend), 32'h08);
        clr[3] = 1'b1;
        tick();
        clr = '0;
        check("irq3_clr", 32'(pend), 32'h00);

        // Pin 4: reset at count 6 discards the count
        filt_en[4] = 1'b1;
        thresh     = 8'd10;
        p2c[4]     = 1'b1;
        repeat (8) tick();
        check("cnt6_val", 32'(val[4]), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_val",  32'(val),  32'h0);
        check("mid_rst_rise", 32'(rise), 32'h0);
        check("mid_rst_fall", 32'(fall), 32'h0);
        check("mid_rst_pend", 32'(pend), 32'h0);
        check("mid_rst_irq",  32'(irq),  32'h0);
        tick();
        check("held_rst_val", 32'(val), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k >= 11) check($sformatf("post_rst_val4_c%0d", k), 32'(val[4]), 32'(k == 12));
        end
        check("post_rst_val_all", 32'(val), 32'h11);

        // Pin 5: threshold lowered mid-count, then zero threshold is bypass
        filt_en[5] = 1'b1;
        thresh     = 8'd200;
        p2c[5]     = 1'b1;
        repeat (152) tick();
        check("cnt150_val", 32'(val[5]), 32'h0);
        thresh = 8'd50;
        tick();
        check("lowered_val", 32'(val[5]), 32'h1);
        check("lowered_rise", 32'(rise[5]), 32'h1);
        thresh = 8'd0;
        p2c[5] = 1'b0;
        repeat (2) tick();
        check("zero_th_val_c2", 32'(val[5]), 32'h1);
        tick();
        check("zero_th_val_c3", 32'(val[5]), 32'h0);
        check("zero_th_fall_c3", 32'(fall[5]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
